// File: rtl/vadd_burst_mmu.sv
// Burst memory unit for the lane-parallel vector adder: reads A and B in bursts, presents each
// A/B word pair to the adder in the same cycle as the B beat, buffers the sums and writes C back.
module vadd_burst_mmu #(
  parameter int MEM_LEN_BITS   = 8,
  parameter int MEM_ADDR_BITS  = 64,
  parameter int MEM_DATA_BITS  = 64,
  parameter int HOST_DATA_BITS = 32,
  parameter int ADDER_BITS     = 8,
  parameter int BURST_LEN      = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  output logic                      mem_req_valid,
  output logic                      mem_req_opcode,
  output logic [MEM_LEN_BITS-1:0]   mem_req_len,
  output logic [MEM_ADDR_BITS-1:0]  mem_req_addr,
  output logic                      mem_wr_valid,
  output logic [MEM_DATA_BITS-1:0]  mem_wr_bits,
  input  logic                      mem_rd_valid,
  input  logic [MEM_DATA_BITS-1:0]  mem_rd_bits,
  output logic                      mem_rd_ready,
  input  logic                      launch,
  output logic                      finish,
  output logic                      event_counter_valid,
  output logic [HOST_DATA_BITS-1:0] event_counter_value,
  input  logic [HOST_DATA_BITS-1:0] length,
  input  logic [HOST_DATA_BITS-1:0] a_addr,
  input  logic [HOST_DATA_BITS-1:0] b_addr,
  input  logic [HOST_DATA_BITS-1:0] c_addr,
  output logic                      a_valid,
  output logic                      b_valid,
  output logic [MEM_DATA_BITS-1:0]  a_data,
  output logic [MEM_DATA_BITS-1:0]  b_data,
  input  logic [MEM_DATA_BITS-1:0]  c_data
);

  localparam int IDX_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [HOST_DATA_BITS-1:0] BURST_H = HOST_DATA_BITS'(BURST_LEN);
  localparam logic [HOST_DATA_BITS-1:0] ONE_H   = HOST_DATA_BITS'(1'b1);

  if ((MEM_DATA_BITS % ADDER_BITS) != 0) begin : g_lane_guard
    $error("MEM_DATA_BITS must be a multiple of ADDER_BITS");
  end

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RD_A_REQ  = 3'd1,
    RD_A_DATA = 3'd2,
    RD_B_REQ  = 3'd3,
    RD_B_DATA = 3'd4,
    WR_REQ    = 3'd5,
    WR_DATA   = 3'd6,
    DONE      = 3'd7
  } state_t;

  state_t                    state_q, state_d;
  logic [IDX_W-1:0]          beat_q, beat_d;
  logic [MEM_LEN_BITS-1:0]   chunk_len_q, chunk_len_d;
  logic [HOST_DATA_BITS-1:0] words_done_q, words_done_d;
  logic [HOST_DATA_BITS-1:0] length_q, length_d;
  logic [HOST_DATA_BITS-1:0] raddr_a_q, raddr_a_d;
  logic [HOST_DATA_BITS-1:0] raddr_b_q, raddr_b_d;
  logic [HOST_DATA_BITS-1:0] waddr_c_q, waddr_c_d;
  logic [HOST_DATA_BITS-1:0] cycle_q, cycle_d;
  logic                      finish_q, finish_d;
  logic [HOST_DATA_BITS-1:0] ecv_value_q, ecv_value_d;
  logic [MEM_DATA_BITS-1:0]  a_buf_q [BURST_LEN];
  logic [MEM_DATA_BITS-1:0]  a_buf_d [BURST_LEN];
  logic [MEM_DATA_BITS-1:0]  c_buf_q [BURST_LEN];
  logic [MEM_DATA_BITS-1:0]  c_buf_d [BURST_LEN];

  logic                      last_beat_s;
  logic [HOST_DATA_BITS-1:0] chunk_words_s;
  logic [HOST_DATA_BITS-1:0] words_next_s;
  logic [HOST_DATA_BITS-1:0] req_addr_s;
  logic                      operand_valid_s;

  // Burst length field (words-1) for the next chunk; remaining is never zero here.
  function automatic logic [MEM_LEN_BITS-1:0] chunk_len_f(input logic [HOST_DATA_BITS-1:0] remaining);
    logic [HOST_DATA_BITS-1:0] n;
    n = (remaining > BURST_H) ? BURST_H : remaining;
    return MEM_LEN_BITS'(n - ONE_H);
  endfunction

  assign last_beat_s   = (MEM_LEN_BITS'(beat_q) == chunk_len_q);
  assign chunk_words_s = HOST_DATA_BITS'(chunk_len_q) + ONE_H;
  assign words_next_s  = words_done_q + chunk_words_s;

  // Next-state, beat sequencing, buffer capture and address advance.
  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    chunk_len_d  = chunk_len_q;
    words_done_d = words_done_q;
    length_d     = length_q;
    raddr_a_d    = raddr_a_q;
    raddr_b_d    = raddr_b_q;
    waddr_c_d    = waddr_c_q;
    a_buf_d      = a_buf_q;
    c_buf_d      = c_buf_q;
    finish_d     = 1'b0;
    ecv_value_d  = '0;
    cycle_d      = (state_q == IDLE) ? '0 : (cycle_q + ONE_H);
    case (state_q)
      IDLE: begin
        length_d     = length;
        raddr_a_d    = a_addr;
        raddr_b_d    = b_addr;
        waddr_c_d    = c_addr;
        words_done_d = '0;
        beat_d       = '0;
        if (launch) begin
          if (length != '0) begin
            state_d     = RD_A_REQ;
            chunk_len_d = chunk_len_f(length);
          end else begin
            state_d = DONE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RD_A_REQ: state_d = RD_A_DATA;
      RD_A_DATA: begin
        if (mem_rd_valid) begin
          a_buf_d[beat_q] = mem_rd_bits;
          if (last_beat_s) begin
            beat_d  = '0;
            state_d = RD_B_REQ;
          end else begin
            beat_d = beat_q + IDX_W'(1'b1);
          end
        end else begin
          state_d = RD_A_DATA;
        end
      end
      RD_B_REQ: state_d = RD_B_DATA;
      RD_B_DATA: begin
        if (mem_rd_valid) begin
          c_buf_d[beat_q] = c_data;
          if (last_beat_s) begin
            beat_d  = '0;
            state_d = WR_REQ;
          end else begin
            beat_d = beat_q + IDX_W'(1'b1);
          end
        end else begin
          state_d = RD_B_DATA;
        end
      end
      WR_REQ: state_d = WR_DATA;
      WR_DATA: begin
        if (last_beat_s) begin
          beat_d       = '0;
          raddr_a_d    = raddr_a_q + chunk_words_s;
          raddr_b_d    = raddr_b_q + chunk_words_s;
          waddr_c_d    = waddr_c_q + chunk_words_s;
          words_done_d = words_next_s;
          if (words_next_s == length_q) begin
            state_d = DONE;
          end else begin
            state_d     = RD_A_REQ;
            chunk_len_d = chunk_len_f(length_q - words_next_s);
          end
        end else begin
          beat_d = beat_q + IDX_W'(1'b1);
        end
      end
      DONE: begin
        finish_d    = 1'b1;
        ecv_value_d = cycle_q + ONE_H;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Memory-port strobes decoded from the current state.
  always_comb begin
    mem_req_valid  = 1'b0;
    mem_req_opcode = 1'b0;
    req_addr_s     = '0;
    mem_rd_ready   = 1'b0;
    mem_wr_valid   = 1'b0;
    case (state_q)
      RD_A_REQ: begin
        mem_req_valid = 1'b1;
        req_addr_s    = raddr_a_q;
      end
      RD_B_REQ: begin
        mem_req_valid = 1'b1;
        req_addr_s    = raddr_b_q;
      end
      WR_REQ: begin
        mem_req_valid  = 1'b1;
        mem_req_opcode = 1'b1;
        req_addr_s     = waddr_c_q;
      end
      RD_A_DATA, RD_B_DATA: mem_rd_ready = 1'b1;
      WR_DATA:              mem_wr_valid = 1'b1;
      default:              mem_req_valid = 1'b0;
    endcase
  end

  assign mem_req_len     = mem_req_valid ? chunk_len_q : '0;
  assign mem_req_addr    = MEM_ADDR_BITS'(req_addr_s);
  assign mem_wr_bits     = mem_wr_valid ? c_buf_q[beat_q] : '0;
  assign operand_valid_s = (state_q == RD_B_DATA) && mem_rd_valid;
  assign a_valid         = operand_valid_s;
  assign b_valid         = operand_valid_s;
  assign a_data          = operand_valid_s ? a_buf_q[beat_q] : '0;
  assign b_data          = operand_valid_s ? mem_rd_bits : '0;
  assign finish              = finish_q;
  assign event_counter_valid = finish_q;
  assign event_counter_value = ecv_value_q;

  // State register; reset aborts any burst in flight and reloads the host values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      beat_q       <= '0;
      chunk_len_q  <= '0;
      words_done_q <= '0;
      length_q     <= length;
      raddr_a_q    <= a_addr;
      raddr_b_q    <= b_addr;
      waddr_c_q    <= c_addr;
      cycle_q      <= '0;
      finish_q     <= 1'b0;
      ecv_value_q  <= '0;
      for (int i = 0; i < BURST_LEN; i++) begin
        a_buf_q[i] <= '0;
        c_buf_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      chunk_len_q  <= chunk_len_d;
      words_done_q <= words_done_d;
      length_q     <= length_d;
      raddr_a_q    <= raddr_a_d;
      raddr_b_q    <= raddr_b_d;
      waddr_c_q    <= waddr_c_d;
      cycle_q      <= cycle_d;
      finish_q     <= finish_d;
      ecv_value_q  <= ecv_value_d;
      a_buf_q      <= a_buf_d;
      c_buf_q      <= c_buf_d;
    end
  end

endmodule

// File: tb/tb_vadd_burst_mmu.sv
// Randomized self-checking bench for vadd_burst_mmu: a memory responder with random read gaps
// plus a job-level model of the expected request sequence, lane sums and completion timing.
`timescale 1ns/1ps
module tb_vadd_burst_mmu;
  localparam int LB = 8, AB = 64, DB = 64, HB = 32, EB = 8, BL = 4, LANES = DB / EB;

  logic          clock = 1'b0;
  logic          reset;
  logic          mem_req_valid, mem_req_opcode, mem_wr_valid, mem_rd_valid, mem_rd_ready;
  logic [LB-1:0] mem_req_len;
  logic [AB-1:0] mem_req_addr;
  logic [DB-1:0] mem_wr_bits, mem_rd_bits, a_data, b_data, c_data;
  logic          launch, finish, event_counter_valid, a_valid, b_valid;
  logic [HB-1:0] event_counter_value, length, a_addr, b_addr, c_addr;

  vadd_burst_mmu dut (
    .clock(clock), .reset(reset),
    .mem_req_valid(mem_req_valid), .mem_req_opcode(mem_req_opcode),
    .mem_req_len(mem_req_len), .mem_req_addr(mem_req_addr),
    .mem_wr_valid(mem_wr_valid), .mem_wr_bits(mem_wr_bits),
    .mem_rd_valid(mem_rd_valid), .mem_rd_bits(mem_rd_bits), .mem_rd_ready(mem_rd_ready),
    .launch(launch), .finish(finish),
    .event_counter_valid(event_counter_valid), .event_counter_value(event_counter_value),
    .length(length), .a_addr(a_addr), .b_addr(b_addr), .c_addr(c_addr),
    .a_valid(a_valid), .b_valid(b_valid), .a_data(a_data), .b_data(b_data), .c_data(c_data)
  );

  always #5 clock = ~clock;

  // The adder: independent per-lane sums, carries dropped at each lane boundary.
  function automatic logic [DB-1:0] lane_add(input logic [DB-1:0] x, input logic [DB-1:0] y);
    logic [DB-1:0] r;
    r = '0;
    for (int i = 0; i < LANES; i++) r[i*EB +: EB] = x[i*EB +: EB] + y[i*EB +: EB];
    return r;
  endfunction

  assign c_data = lane_add(a_data, b_data);

  typedef struct {
    logic          op;
    logic [LB-1:0] len;
    logic [HB-1:0] host;
    logic          isb;
    int            off;
  } req_t;

  logic [DB-1:0] mem [logic [AB-1:0]];
  req_t          exp_q [$];
  logic [DB-1:0] last_wr;
  int            n_checks = 0;
  int            n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_ctrl"}, {mem_req_valid, mem_req_opcode, mem_wr_valid, mem_rd_ready,
                              finish, event_counter_valid, a_valid, b_valid}, 64'd0);
    check_eq({tag, "_req"}, {mem_req_len, mem_req_addr[31:0]}, 64'd0);
    check_eq({tag, "_wr_bits"}, mem_wr_bits, 64'd0);
    check_eq({tag, "_ab_data"}, a_data | b_data, 64'd0);
    check_eq({tag, "_ecv_value"}, event_counter_value, 64'd0);
  endtask

  function automatic logic [AB-1:0] zx(input logic [HB-1:0] h);
    return {32'd0, h};
  endfunction

  task automatic run_job(input logic [HB-1:0] len, input logic [HB-1:0] a, input logic [HB-1:0] b,
                         input logic [HB-1:0] c, input int gap_max, input bit abort,
                         input bit fixed, input logic [DB-1:0] fa, input logic [DB-1:0] fb);
    logic [DB-1:0] exp_c [$];
    logic [DB-1:0] wa, wb;
    req_t          r;
    int            n, exp_val, cyc, post, fin_cnt, fin_cyc, av_cnt, wr_idx, wr_left;
    int            beats_left, gap_left, rd_k, rd_off;
    logic [HB-1:0] rd_host, fin_val;
    logic          rd_is_b, exp_av, aborted;

    exp_q.delete();
    for (int i = 0; i < int'(len); i++) begin
      wa = fixed ? fa : {$urandom, $urandom};
      wb = fixed ? fb : {$urandom, $urandom};
      mem[zx(a + HB'(i))] = wa;
      mem[zx(b + HB'(i))] = wb;
      exp_c.push_back(lane_add(wa, wb));
    end
    exp_val = 1;
    for (int off = 0; off < int'(len); off += n) begin
      n = (int'(len) - off > BL) ? BL : int'(len) - off;
      exp_q.push_back('{1'b0, LB'(n - 1), a + HB'(off), 1'b0, off});
      exp_q.push_back('{1'b0, LB'(n - 1), b + HB'(off), 1'b1, off});
      exp_q.push_back('{1'b1, LB'(n - 1), c + HB'(off), 1'b0, off});
      exp_val += 3 + 3 * n;
    end

    cyc = 0; post = 0; fin_cnt = 0; fin_cyc = -1; fin_val = '0; av_cnt = 0; wr_idx = 0;
    wr_left = 0; beats_left = 0; gap_left = 0; rd_k = 0; rd_off = 0; rd_host = '0;
    rd_is_b = 1'b0; aborted = 1'b0;
    while ((fin_cnt == 0 || post < 4) && cyc < 3000) begin
      @(posedge clock); #1;
      if (cyc == 0) begin
        launch = 1'b1; length = len; a_addr = a; b_addr = b; c_addr = c;
      end else begin
        launch = (beats_left > 0) && ($urandom_range(0, 3) == 0);
        length = $urandom; a_addr = $urandom; b_addr = $urandom; c_addr = $urandom;
      end
      if (beats_left > 0 && gap_left == 0) begin
        mem_rd_valid = 1'b1;
        mem_rd_bits  = mem[zx(rd_host + HB'(rd_k))];
      end else if (beats_left > 0) begin
        mem_rd_valid = 1'b0;
        mem_rd_bits  = {$urandom, $urandom};
        gap_left--;
      end else begin
        mem_rd_valid = ($urandom_range(0, 3) == 0);
        mem_rd_bits  = {$urandom, $urandom};
      end

      @(negedge clock);
      check_eq("rd_ready", mem_rd_ready, beats_left > 0);
      exp_av = (beats_left > 0) && mem_rd_valid && rd_is_b;
      check_eq("a_valid", a_valid, exp_av);
      check_eq("b_valid", b_valid, exp_av);
      if (beats_left > 0 && mem_rd_valid) begin
        if (rd_is_b) begin
          check_eq("a_data", a_data, mem[zx(a + HB'(rd_off + rd_k))]);
          check_eq("b_data", b_data, mem[zx(b + HB'(rd_off + rd_k))]);
          av_cnt++;
        end
        rd_k++;
        beats_left--;
        gap_left = $urandom_range(0, gap_max);
      end
      check_eq("wr_valid", mem_wr_valid, wr_left > 0);
      if (mem_wr_valid && wr_left > 0) begin
        check_eq("wr_data", mem_wr_bits, exp_c[wr_idx]);
        last_wr = mem_wr_bits;
        wr_idx++;
        wr_left--;
      end
      if (mem_req_valid) begin
        check_eq("req_expected", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) begin
          r = exp_q.pop_front();
          check_eq("req_opcode", mem_req_opcode, r.op);
          check_eq("req_len", mem_req_len, r.len);
          check_eq("req_addr", mem_req_addr, zx(r.host));
          if (r.op) begin
            wr_left = int'(r.len) + 1;
          end else begin
            beats_left = int'(r.len) + 1;
            rd_host = r.host; rd_is_b = r.isb; rd_off = r.off; rd_k = 0;
            gap_left = $urandom_range(0, gap_max);
          end
        end
      end
      check_eq("ecv_valid", event_counter_valid, finish);
      if (finish) begin
        fin_cnt++; fin_cyc = cyc; fin_val = event_counter_value;
      end
      if (fin_cnt > 0) post++;
      cyc++;
      if (abort && a_valid) begin
        aborted = 1'b1;
        break;
      end
    end
    launch = 1'b0;

    if (abort) begin
      check_eq("abort_reached", aborted, 1'b1);
      @(posedge clock); #1;
      reset = 1'b1; mem_rd_valid = 1'b1; mem_rd_bits = {$urandom, $urandom};
      @(posedge clock); #1;
      reset = 1'b0; mem_rd_valid = 1'b1; mem_rd_bits = {$urandom, $urandom};
      @(negedge clock);
      check_idle("abort");
      @(posedge clock); #1;
      mem_rd_valid = 1'b0;
    end else begin
      check_eq("finish_count", fin_cnt, 1);
      check_eq("a_valid_count", av_cnt, len);
      check_eq("write_words", wr_idx, len);
      check_eq("reqs_outstanding", exp_q.size(), 0);
      if (gap_max == 0) begin
        check_eq("ecv_value", fin_val, exp_val);
        check_eq("finish_cycle", fin_cyc, exp_val + 1);
      end
    end
  endtask

  initial begin
    logic [HB-1:0] base;
    reset = 1'b1; launch = 1'b0; mem_rd_valid = 1'b0; mem_rd_bits = '0;
    length = '0; a_addr = '0; b_addr = '0; c_addr = '0; last_wr = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_idle("reset");
    @(posedge clock); #1;
    reset = 1'b0;
    repeat (2) @(posedge clock);

    run_job(32'd1, 32'h100, 32'h200, 32'h300, 0, 1'b0, 1'b1,
            64'h0807060504030201, 64'h11100F0E0D0C0B0A);
    check_eq("lanes_1to8_sum", last_wr, 64'h19171513110F0D0B);
    run_job(32'd6, 32'h1000, 32'h2000, 32'h3000, 0, 1'b0, 1'b0, 64'd0, 64'd0);
    run_job(32'd0, 32'h40, 32'h50, 32'h60, 0, 1'b0, 1'b0, 64'd0, 64'd0);
    run_job(32'd1, 32'h500, 32'h600, 32'h700, 0, 1'b0, 1'b1,
            64'h01020304050607FF, 64'h0000000000000001);
    check_eq("lane_overflow", last_wr, 64'h0102030405060700);
    run_job(32'd5, 32'h800, 32'h900, 32'hA00, 2, 1'b1, 1'b0, 64'd0, 64'd0);
    run_job(32'd5, 32'h800, 32'h900, 32'hA00, 2, 1'b0, 1'b0, 64'd0, 64'd0);
    run_job(32'd6, 32'hFFFF_FFFE, 32'h10, 32'h2_0000, 1, 1'b0, 1'b0, 64'd0, 64'd0);
    for (int j = 0; j < 8; j++) begin
      base = $urandom & 32'hFFFF_0000;
      run_job(HB'($urandom_range(1, 11)), base, base + 32'h100, base + 32'h200,
              (j % 2 == 0) ? 3 : 0, 1'b0, 1'b0, 64'd0, 64'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
